// File: rtl/pe_array_ctrl_if.sv
// Control/handshake bundle between the tile issuer and pe_array_ctrl.
// The issuer drives start/abort/config/out_ready, and the controller returns busy/done/out_valid.
interface pe_array_ctrl_if #(
  parameter int unsigned HEIGHT_BITWIDTH = 8,
  parameter int unsigned M_END_BITWIDTH  = 8
);
  logic                       start;
  logic                       abort;
  logic [HEIGHT_BITWIDTH-1:0] input_height;
  logic [M_END_BITWIDTH-1:0]  m_end_cfg;
  logic                       out_ready;
  logic                       busy;
  logic                       done;
  logic                       out_valid;

  modport master (
    output start, abort, input_height, m_end_cfg, out_ready,
    input  busy, done, out_valid
  );

  modport slave (
    input  start, abort, input_height, m_end_cfg, out_ready,
    output busy, done, out_valid
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for the unary-stochastic PE_array: weight load, per-vector multiply/passby/drain.
// Optional PE_CTRL_WEIGHT_REUSE_EN adds reuse_weights, which skips the weight load phase.
module pe_array_ctrl #(
  parameter int unsigned ROW_NUM         = 4,
  parameter int unsigned COLUMN_NUM      = 4,
  parameter int unsigned UNARY_CYCLES    = 16,
  parameter int unsigned M_END_BITWIDTH  = 8,
  parameter int unsigned HEIGHT_BITWIDTH = 8,
  localparam int unsigned ROW_IDX_W      = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1
) (
  input  logic                                    clk,
  input  logic                                    resetn,
`ifdef PE_CTRL_WEIGHT_REUSE_EN
  input  logic                                    reuse_weights,
`endif
  pe_array_ctrl_if.slave                          ctrl,
  output logic                                    weight_buf_rd_en,
  output logic [ROW_IDX_W-1:0]                    weight_row_idx,
  output logic                                    input_buf_rd_en,
  output logic                                    rand_gen_en,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]      weight_reg_en,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]      weight_reg_r0w1,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]      input_reg_en,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]      input_reg_r0w1,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]      rand_num_reg_en,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]      rand_num_reg_r0w1,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]      output_num_reg_en,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]      output_num_reg_r0w1,
  output logic [ROW_NUM-1:0][M_END_BITWIDTH-1:0]  M_end
);

  localparam int unsigned CNT_MAX = (UNARY_CYCLES > ROW_NUM) ? UNARY_CYCLES : ROW_NUM;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_COMPUTE,
    ST_PASSBY,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [HEIGHT_BITWIDTH-1:0] height_q, height_d;
  logic [HEIGHT_BITWIDTH-1:0] vec_q, vec_d;
  logic [M_END_BITWIDTH-1:0]  m_end_q, m_end_d;
  logic                       start_pend_q, start_pend_d;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
  logic                       reuse_q, reuse_d;
`endif

  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;
  logic                                   out_valid_q, out_valid_d;
  logic                                   weight_buf_rd_en_q, weight_buf_rd_en_d;
  logic [ROW_IDX_W-1:0]                   weight_row_idx_q, weight_row_idx_d;
  logic                                   input_buf_rd_en_q, input_buf_rd_en_d;
  logic                                   rand_gen_en_q, rand_gen_en_d;
  logic [ROW_NUM-1:0][COLUMN_NUM-1:0]     weight_reg_en_q, weight_reg_en_d;
  logic [ROW_NUM-1:0][COLUMN_NUM-1:0]     weight_reg_r0w1_q, weight_reg_r0w1_d;
  logic [ROW_NUM-1:0][COLUMN_NUM-1:0]     input_reg_en_q, input_reg_en_d;
  logic [ROW_NUM-1:0][COLUMN_NUM-1:0]     input_reg_r0w1_q, input_reg_r0w1_d;
  logic [ROW_NUM-1:0][COLUMN_NUM-1:0]     rand_num_reg_en_q, rand_num_reg_en_d;
  logic [ROW_NUM-1:0][COLUMN_NUM-1:0]     rand_num_reg_r0w1_q, rand_num_reg_r0w1_d;
  logic [ROW_NUM-1:0][COLUMN_NUM-1:0]     output_num_reg_en_q, output_num_reg_en_d;
  logic [ROW_NUM-1:0][COLUMN_NUM-1:0]     output_num_reg_r0w1_q, output_num_reg_r0w1_d;
  logic [ROW_NUM-1:0][M_END_BITWIDTH-1:0] M_end_q, M_end_d;

  // start is captured into start_pend one edge before the tile begins, so the
  // first tile cycle is the one after the edge following the sampling edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vec_d        = vec_q;
    height_d     = height_q;
    m_end_d      = m_end_q;
    start_pend_d = 1'b0;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    reuse_d      = reuse_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start_pend_q) begin
          cnt_d = '0;
          vec_d = '0;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
          if (reuse_q) state_d = (height_q != '0) ? ST_COMPUTE : ST_DONE;
          else         state_d = ST_LOAD_W;
`else
          state_d = ST_LOAD_W;
`endif
        end else if (ctrl.start) begin
          start_pend_d = 1'b1;
          height_d     = ctrl.input_height;
          m_end_d      = ctrl.m_end_cfg;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
          reuse_d      = reuse_weights;
`endif
        end
      end
      ST_LOAD_W: begin
        if (cnt_q == CNT_W'(ROW_NUM - 1)) begin
          cnt_d   = '0;
          state_d = (height_q != '0) ? ST_COMPUTE : ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == CNT_W'(UNARY_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_PASSBY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PASSBY: state_d = ST_DRAIN;
      ST_DRAIN: begin
        // out_valid is decoded from this same state, so state alone marks the handshake
        if (ctrl.out_ready) begin
          if (vec_q + HEIGHT_BITWIDTH'(1) == height_q) begin
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + HEIGHT_BITWIDTH'(1);
            cnt_d   = '0;
            state_d = ST_COMPUTE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (ctrl.abort) begin
      state_d      = ST_IDLE;
      start_pend_d = 1'b0;
      cnt_d        = '0;
      vec_d        = '0;
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    busy_d                = 1'b0;
    done_d                = 1'b0;
    out_valid_d           = 1'b0;
    weight_buf_rd_en_d    = 1'b0;
    weight_row_idx_d      = '0;
    input_buf_rd_en_d     = 1'b0;
    rand_gen_en_d         = 1'b0;
    weight_reg_en_d       = '0;
    weight_reg_r0w1_d     = '0;
    input_reg_en_d        = '0;
    input_reg_r0w1_d      = '0;
    rand_num_reg_en_d     = '0;
    rand_num_reg_r0w1_d   = '0;
    output_num_reg_en_d   = '0;
    output_num_reg_r0w1_d = '0;
    M_end_d               = '0;
    unique case (state_d)
      ST_LOAD_W: begin
        weight_buf_rd_en_d = 1'b1;
        weight_row_idx_d   = ROW_IDX_W'(cnt_d);
        for (int unsigned r = 0; r < ROW_NUM; r++) begin
          if (cnt_d == CNT_W'(r)) begin
            weight_reg_en_d[r]   = '1;
            weight_reg_r0w1_d[r] = '1;
          end
        end
      end
      ST_COMPUTE: begin
        rand_gen_en_d = 1'b1;
        if (cnt_d == '0) begin
          input_buf_rd_en_d = 1'b1;
          input_reg_en_d    = '1;
          input_reg_r0w1_d  = '1;
        end
        for (int unsigned r = 0; r < ROW_NUM; r++) begin
          rand_num_reg_en_d[r][0]   = 1'b1;
          rand_num_reg_r0w1_d[r][0] = 1'b1;
        end
      end
      ST_PASSBY: begin
        output_num_reg_en_d   = '1;
        output_num_reg_r0w1_d = '1;
      end
      ST_DRAIN: begin
        out_valid_d         = 1'b1;
        output_num_reg_en_d = '1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
    if (state_d != ST_IDLE) begin
      busy_d = 1'b1;
      for (int unsigned r = 0; r < ROW_NUM; r++) M_end_d[r] = m_end_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      vec_q        <= '0;
      height_q     <= '0;
      m_end_q      <= '0;
      start_pend_q <= 1'b0;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
      reuse_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_q        <= vec_d;
      height_q     <= height_d;
      m_end_q      <= m_end_d;
      start_pend_q <= start_pend_d;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
      reuse_q      <= reuse_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q                <= 1'b0;
      done_q                <= 1'b0;
      out_valid_q           <= 1'b0;
      weight_buf_rd_en_q    <= 1'b0;
      weight_row_idx_q      <= '0;
      input_buf_rd_en_q     <= 1'b0;
      rand_gen_en_q         <= 1'b0;
      weight_reg_en_q       <= '0;
      weight_reg_r0w1_q     <= '0;
      input_reg_en_q        <= '0;
      input_reg_r0w1_q      <= '0;
      rand_num_reg_en_q     <= '0;
      rand_num_reg_r0w1_q   <= '0;
      output_num_reg_en_q   <= '0;
      output_num_reg_r0w1_q <= '0;
      M_end_q               <= '0;
    end else begin
      busy_q                <= busy_d;
      done_q                <= done_d;
      out_valid_q           <= out_valid_d;
      weight_buf_rd_en_q    <= weight_buf_rd_en_d;
      weight_row_idx_q      <= weight_row_idx_d;
      input_buf_rd_en_q     <= input_buf_rd_en_d;
      rand_gen_en_q         <= rand_gen_en_d;
      weight_reg_en_q       <= weight_reg_en_d;
      weight_reg_r0w1_q     <= weight_reg_r0w1_d;
      input_reg_en_q        <= input_reg_en_d;
      input_reg_r0w1_q      <= input_reg_r0w1_d;
      rand_num_reg_en_q     <= rand_num_reg_en_d;
      rand_num_reg_r0w1_q   <= rand_num_reg_r0w1_d;
      output_num_reg_en_q   <= output_num_reg_en_d;
      output_num_reg_r0w1_q <= output_num_reg_r0w1_d;
      M_end_q               <= M_end_d;
    end
  end

  assign ctrl.busy           = busy_q;
  assign ctrl.done           = done_q;
  assign ctrl.out_valid      = out_valid_q;
  assign weight_buf_rd_en    = weight_buf_rd_en_q;
  assign weight_row_idx      = weight_row_idx_q;
  assign input_buf_rd_en     = input_buf_rd_en_q;
  assign rand_gen_en         = rand_gen_en_q;
  assign weight_reg_en       = weight_reg_en_q;
  assign weight_reg_r0w1     = weight_reg_r0w1_q;
  assign input_reg_en        = input_reg_en_q;
  assign input_reg_r0w1      = input_reg_r0w1_q;
  assign rand_num_reg_en     = rand_num_reg_en_q;
  assign rand_num_reg_r0w1   = rand_num_reg_r0w1_q;
  assign output_num_reg_en   = output_num_reg_en_q;
  assign output_num_reg_r0w1 = output_num_reg_r0w1_q;
  assign M_end               = M_end_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: per-cycle expected output snapshots are queued when a
// tile is launched and popped/compared every cycle on the falling edge.
module tb_pe_array_ctrl;
  localparam int unsigned R  = 4;
  localparam int unsigned C  = 4;
  localparam int unsigned U  = 16;
  localparam int unsigned MW = 8;
  localparam int unsigned HW = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pe_array_ctrl_if #(.HEIGHT_BITWIDTH(HW), .M_END_BITWIDTH(MW)) ctrl_if ();
`ifdef PE_CTRL_WEIGHT_REUSE_EN
  logic reuse_weights = 1'b0;
`endif

  logic                       weight_buf_rd_en, input_buf_rd_en, rand_gen_en;
  logic [1:0]                 weight_row_idx;
  logic [R-1:0][C-1:0]        w_en, w_rw, i_en, i_rw, r_en, r_rw, o_en, o_rw;
  logic [R-1:0][MW-1:0]       m_end_o;

  pe_array_ctrl #(
    .ROW_NUM(R), .COLUMN_NUM(C), .UNARY_CYCLES(U), .M_END_BITWIDTH(MW), .HEIGHT_BITWIDTH(HW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    .reuse_weights(reuse_weights),
`endif
    .ctrl(ctrl_if),
    .weight_buf_rd_en(weight_buf_rd_en),
    .weight_row_idx(weight_row_idx),
    .input_buf_rd_en(input_buf_rd_en),
    .rand_gen_en(rand_gen_en),
    .weight_reg_en(w_en),
    .weight_reg_r0w1(w_rw),
    .input_reg_en(i_en),
    .input_reg_r0w1(i_rw),
    .rand_num_reg_en(r_en),
    .rand_num_reg_r0w1(r_rw),
    .output_num_reg_en(o_en),
    .output_num_reg_r0w1(o_rw),
    .M_end(m_end_o)
  );

  typedef struct packed {
    logic        busy, done, out_valid, wbuf, ibuf, rgen;
    logic [1:0]  wrow;
    logic [15:0] w_en, w_rw, i_en, i_rw, r_en, r_rw, o_en, o_rw;
    logic [31:0] m_end;
  } snap_t;

  snap_t obs;
  always_comb begin
    obs           = '0;
    obs.busy      = ctrl_if.busy;
    obs.done      = ctrl_if.done;
    obs.out_valid = ctrl_if.out_valid;
    obs.wbuf      = weight_buf_rd_en;
    obs.ibuf      = input_buf_rd_en;
    obs.rgen      = rand_gen_en;
    obs.wrow      = weight_row_idx;
    obs.w_en      = w_en;
    obs.w_rw      = w_rw;
    obs.i_en      = i_en;
    obs.i_rw      = i_rw;
    obs.r_en      = r_en;
    obs.r_rw      = r_rw;
    obs.o_en      = o_en;
    obs.o_rw      = o_rw;
    obs.m_end     = m_end_o;
  end

  snap_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc, abort_cyc, stop_cyc, stall_len, rdy_lo_start, busy_start_cyc;
  bit    aborted;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_snap(input string where, input snap_t o, input snap_t e);
    check_eq({where, " ctrl"},  {o.busy, o.done, o.out_valid, o.wbuf, o.ibuf, o.rgen},
                                {e.busy, e.done, e.out_valid, e.wbuf, e.ibuf, e.rgen});
    check_eq({where, " wrow"},  o.wrow,  e.wrow);
    check_eq({where, " w_en"},  o.w_en,  e.w_en);
    check_eq({where, " w_rw"},  o.w_rw,  e.w_rw);
    check_eq({where, " i_en"},  o.i_en,  e.i_en);
    check_eq({where, " i_rw"},  o.i_rw,  e.i_rw);
    check_eq({where, " r_en"},  o.r_en,  e.r_en);
    check_eq({where, " r_rw"},  o.r_rw,  e.r_rw);
    check_eq({where, " o_en"},  o.o_en,  e.o_en);
    check_eq({where, " o_rw"},  o.o_rw,  e.o_rw);
    check_eq({where, " m_end"}, o.m_end, e.m_end);
  endtask

  function automatic snap_t busy_s(input logic [7:0] m);
    snap_t s = '0;
    s.busy  = 1'b1;
    s.m_end = {R{m}};
    return s;
  endfunction

  task automatic push_s(input snap_t s);
    if (aborted) return;
    if (stop_cyc != 0 && cyc > stop_cyc) return;
    exp_q.push_back(s);
    if (cyc == abort_cyc) aborted = 1'b1;
    cyc++;
  endtask

  // Expected trace from the timing rules: cycle 1 is the first cycle after the edge following start.
  task automatic push_tile(input int h, input logic [7:0] m, input bit reuse);
    snap_t s;
    cyc     = 1;
    aborted = 1'b0;
    if (!reuse) begin
      for (int r = 0; r < R; r++) begin
        s      = busy_s(m);
        s.wbuf = 1'b1;
        s.wrow = 2'(r);
        s.w_en = 16'h000F << (C * r);
        s.w_rw = 16'h000F << (C * r);
        push_s(s);
      end
    end
    for (int v = 0; v < h; v++) begin
      for (int j = 0; j < U; j++) begin
        s      = busy_s(m);
        s.rgen = 1'b1;
        s.r_en = 16'h1111;
        s.r_rw = 16'h1111;
        if (j == 0) begin
          s.ibuf = 1'b1;
          s.i_en = 16'hFFFF;
          s.i_rw = 16'hFFFF;
        end
        push_s(s);
      end
      s      = busy_s(m);
      s.o_en = 16'hFFFF;
      s.o_rw = 16'hFFFF;
      push_s(s);
      for (int k = 0; k <= ((v == 0) ? stall_len : 0); k++) begin
        if (v == 0 && k == 0) rdy_lo_start = cyc;
        s           = busy_s(m);
        s.out_valid = 1'b1;
        s.o_en      = 16'hFFFF;
        push_s(s);
      end
    end
    s      = busy_s(m);
    s.done = 1'b1;
    push_s(s);
    if (stop_cyc == 0) begin
      aborted = 1'b0;
      push_s('0);
      push_s('0);
    end
  endtask

  task automatic run_tile(input string name, input int h, input logic [7:0] m, input bit reuse);
    snap_t e;
    int    n;
    @(posedge clk); #1;
    ctrl_if.input_height = h[HW-1:0];
    ctrl_if.m_end_cfg    = m;
    ctrl_if.out_ready    = 1'b1;
    ctrl_if.start        = 1'b1;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    reuse_weights = reuse;
`endif
    push_tile(h, m, reuse);
    @(posedge clk); #1;
    ctrl_if.start        = 1'b0;
    ctrl_if.input_height = ~h[HW-1:0];
    ctrl_if.m_end_cfg    = ~m;
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    reuse_weights = ~reuse;
`endif
    n = 1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      ctrl_if.out_ready = !(stall_len > 0 && n >= rdy_lo_start && n < rdy_lo_start + stall_len);
      ctrl_if.abort     = (n == abort_cyc);
      ctrl_if.start     = (n == busy_start_cyc);
      @(negedge clk);
      e = exp_q.pop_front();
      check_snap($sformatf("%s c%0d", name, n), obs, e);
      n++;
    end
    ctrl_if.abort = 1'b0;
    ctrl_if.start = 1'b0;
  endtask

  task automatic idle_checks(input string name, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check_snap($sformatf("%s idle%0d", name, i), obs, '0);
    end
  endtask

  task automatic clear_knobs();
    abort_cyc      = 0;
    stop_cyc       = 0;
    stall_len      = 0;
    rdy_lo_start   = 0;
    busy_start_cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_if.start        = 1'b0;
    ctrl_if.abort        = 1'b0;
    ctrl_if.input_height = '0;
    ctrl_if.m_end_cfg    = '0;
    ctrl_if.out_ready    = 1'b1;
    clear_knobs();
    #12;
    check_snap("reset", obs, '0);
    @(negedge clk);
    resetn = 1'b1;
    idle_checks("post_reset", 2);

    run_tile("basic", 2, 8'hA5, 1'b0);

    clear_knobs();
    stall_len = 5;
    run_tile("bp", 1, 8'h3C, 1'b0);

    clear_knobs();
    run_tile("h0", 0, 8'h11, 1'b0);

    clear_knobs();
    abort_cyc = R + 1 + 7;
    run_tile("abort", 2, 8'h5A, 1'b0);
    clear_knobs();
    run_tile("restart", 1, 8'hC3, 1'b0);

    clear_knobs();
    stall_len      = 10;
    stop_cyc       = R + U + 4;
    busy_start_cyc = 10;
    run_tile("rst", 1, 8'h77, 1'b0);
    #1 resetn = 1'b0;
    #1 check_snap("rst async", obs, '0);
    @(negedge clk);
    resetn = 1'b1;
    ctrl_if.out_ready = 1'b1;
    clear_knobs();
    idle_checks("rst", 3);
    run_tile("after_rst", 1, 8'h42, 1'b0);

`ifdef PE_CTRL_WEIGHT_REUSE_EN
    clear_knobs();
    run_tile("reuse", 1, 8'h9E, 1'b1);
    clear_knobs();
    run_tile("reuse_h0", 0, 8'h01, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
